regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources:
- Source 0: execute-stage writeback (ALU/CSR results).
- Source 1: late load responses from the data-memory interface.

It also keeps a 32-entry pending-load scoreboard, so the decode stage can stall when it reads a register whose load has not returned. It sits between the pipeline writeback paths and the register file's write_en/rd/write_data inputs.

---
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between execute writeback and late load
// responses, and tracks outstanding loads in a 32-entry pending scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data
);

  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     pending_q, pending_d;
  logic            write_en_q, write_en_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic            starved;
  logic            ex_xfer, ld_xfer;

  assign starved = (wait_cnt_q == 4'(MAX_WAIT));

  // Source 0 wins by default; source 1 preempts once it has been refused MAX_WAIT times.
  always_comb begin
    ex_ready = 1'b0;
    ld_ready = 1'b0;
    if (!rst) begin
      if (ld_valid && (!ex_valid || starved)) begin
        ld_ready = 1'b1;
      end else if (ex_valid) begin
        ex_ready = 1'b1;
      end
    end
  end

  assign ex_xfer = ex_valid & ex_ready;
  assign ld_xfer = ld_valid & ld_ready;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (ld_xfer) begin
      wait_cnt_d = 4'd0;
    end else if (ld_valid && !starved) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    write_en_d   = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (ld_xfer) begin
      write_en_d   = (ld_rd != 5'd0);
      rd_d         = ld_rd;
      write_data_d = ld_data;
    end else if (ex_xfer) begin
      write_en_d   = (ex_rd != 5'd0);
      rd_d         = ex_rd;
      write_data_d = ex_data;
    end
  end

  // Set is applied after clear so a back-to-back load to the same rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (ld_xfer) begin
      pending_d[ld_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q   <= 4'd0;
      pending_q    <= 32'd0;
      write_en_q   <= 1'b0;
      rd_q         <= 5'd0;
      write_data_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pending_q    <= pending_d;
      write_en_q   <= write_en_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  assign rs1_busy   = pending_q[rs1_in];
  assign rs2_busy   = pending_q[rs2_in];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, writeback and the pending scoreboard.
module tb_regfile_wb_arbiter;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned XLEN     = 32;

  logic            clk;
  logic            rst;
  logic            ex_valid, ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ld_valid, ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_in, rs2_in;
  logic            rs1_busy, rs2_busy;
  logic            write_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;

  int n_total = 0;
  int n_pass  = 0;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rs1_in     (rs1_in),
    .rs2_in     (rs2_in),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .write_en   (write_en),
    .rd         (rd),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after each posedge; registered outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_valid = 0; issue_rd = 0;
    rs1_in = 0; rs2_in = 0;
  endtask

  task automatic test_reset();
    bit any_busy;
    idle_inputs();
    rst = 1; ex_valid = 1; ld_valid = 1;
    #2;
    n_total++; if (ex_ready !== 1'b0) $display("FAIL reset_ex_ready got %b want 0", ex_ready); else n_pass++;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b want 0", ld_ready); else n_pass++;
    n_total++; if (write_en !== 1'b0 || rd !== 5'd0 || write_data !== '0)
      $display("FAIL reset_outputs got we=%b rd=%0d data=%h want 0/0/0", write_en, rd, write_data);
    else n_pass++;
    tick();
    rst = 0;
    ld_valid = 0;
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hCAFE_0005;
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    idle_inputs();
    n_total++; if (write_en !== 1'b1) $display("FAIL reset_pre_we got %b want 1", write_en); else n_pass++;
    #2 rst = 1;
    #1;
    n_total++; if (write_en !== 1'b0) $display("FAIL reset_async_we got %b want 0", write_en); else n_pass++;
    any_busy = 0;
    for (int i = 0; i < 32; i++) begin
      rs1_in = 5'(i);
      #0.1;
      if (rs1_busy !== 1'b0) any_busy = 1;
    end
    n_total++; if (any_busy) $display("FAIL reset_async_busy got busy want none"); else n_pass++;
    @(negedge clk) rst = 0;
    tick();
  endtask

  task automatic test_single();
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
    #1;
    n_total++; if (ex_ready !== 1'b1) $display("FAIL single_ready got %b want 1", ex_ready); else n_pass++;
    tick();
    ex_valid = 0;
    n_total++; if (write_en !== 1'b1 || rd !== 5'd5 || write_data !== 32'hDEAD_BEEF)
      $display("FAIL single_write got we=%b rd=%0d data=%h want 1/5/deadbeef", write_en, rd, write_data);
    else n_pass++;
    tick();
    n_total++; if (write_en !== 1'b0) $display("FAIL single_idle got we=%b want 0", write_en); else n_pass++;
  endtask

  task automatic test_contention();
    logic [4:0] want_rd;
    ex_valid = 1; ex_rd = 5'd10; ex_data = 32'hE000_0000;
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'hA5A5_0007;
    for (int c = 0; c < 6; c++) begin
      if (c >= 1 && c <= 4) begin
        ex_rd = 5'(10 + c); ex_data = 32'hE000_0000 + 32'(c);
      end
      if (c == 5) ld_data = 32'h5A5A_0007;
      #1;
      n_total++;
      if (ex_ready !== (c != 4) || ld_ready !== (c == 4))
        $display("FAIL contention_ready c=%0d got ex=%b ld=%b want ex=%b ld=%b",
                 c, ex_ready, ld_ready, c != 4, c == 4);
      else n_pass++;
      tick();
      want_rd = (c == 4) ? 5'd7 : (c == 5) ? 5'd14 : 5'(10 + c);
      n_total++;
      if (write_en !== 1'b1 || rd !== want_rd)
        $display("FAIL contention_write c=%0d got we=%b rd=%0d want 1/%0d", c, write_en, rd, want_rd);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    ld_valid = 1; ld_rd = 5'd0; ld_data = 32'h1234;
    #1;
    n_total++; if (ld_ready !== 1'b1) $display("FAIL x0_ready got %b want 1", ld_ready); else n_pass++;
    tick();
    ld_valid = 0;
    n_total++; if (write_en !== 1'b0) $display("FAIL x0_write got we=%b want 0", write_en); else n_pass++;
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    issue_valid = 0; rs1_in = 5'd0; #1;
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL x0_issue_busy got %b want 0", rs1_busy); else n_pass++;
  endtask

  task automatic test_scoreboard();
    rs1_in = 5'd9;
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    n_total++; if (rs1_busy !== 1'b1) $display("FAIL sb_set got %b want 1", rs1_busy); else n_pass++;
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h9999;
    tick();
    ld_valid = 0;
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL sb_clear got %b want 0", rs1_busy); else n_pass++;
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    ld_valid = 1; ld_rd = 5'd9;
    tick();
    issue_valid = 0; ld_valid = 0;
    n_total++; if (rs1_busy !== 1'b1) $display("FAIL sb_set_wins got %b want 1", rs1_busy); else n_pass++;
    ld_valid = 1;
    tick();
    ld_valid = 0;
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL sb_final_clear got %b want 0", rs1_busy); else n_pass++;
  endtask

  task automatic test_dual();
    issue_valid = 1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    issue_valid = 0;
    rs1_in = 5'd3; rs2_in = 5'd4;
    #1;
    n_total++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1)
      $display("FAIL dual_busy got %b%b want 11", rs1_busy, rs2_busy);
    else n_pass++;
    ex_valid = 1; ex_rd = 5'd3; ex_data = 32'h3333;
    tick();
    ex_valid = 0;
    n_total++; if (write_en !== 1'b1 || rd !== 5'd3 || rs1_busy !== 1'b1)
      $display("FAIL dual_ex_nobypass got we=%b rd=%0d busy=%b want 1/3/1", write_en, rd, rs1_busy);
    else n_pass++;
  endtask

  task automatic test_random();
    bit              m_pending[32];
    int              m_wait;
    bit              m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    bit              ex_hold, ld_hold, exp_ex, exp_ld;
    idle_inputs();
    #2 rst = 1;
    @(negedge clk) rst = 0;
    tick();
    foreach (m_pending[i]) m_pending[i] = 0;
    m_wait = 0; ex_hold = 0; ld_hold = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!ex_hold) begin
        ex_valid = ($urandom_range(0, 99) < 60);
        ex_rd = 5'($urandom_range(0, 7)); ex_data = $urandom;
      end
      if (!ld_hold) begin
        ld_valid = ($urandom_range(0, 99) < 50);
        ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd = 5'($urandom_range(0, 7));
      rs1_in = 5'($urandom_range(0, 8)); rs2_in = 5'($urandom_range(0, 8));
      // A load source refused MAX_WAIT consecutive times gets the port next.
      exp_ld = ld_valid && (!ex_valid || m_wait >= int'(MAX_WAIT));
      exp_ex = ex_valid && !exp_ld;
      #1;
      n_total++;
      if (ex_ready !== exp_ex || ld_ready !== exp_ld)
        $display("FAIL rand_ready cyc=%0d got ex=%b ld=%b want ex=%b ld=%b",
                 cyc, ex_ready, ld_ready, exp_ex, exp_ld);
      else n_pass++;
      n_total++;
      if (rs1_busy !== m_pending[rs1_in] || rs2_busy !== m_pending[rs2_in])
        $display("FAIL rand_busy cyc=%0d got %b%b want %b%b",
                 cyc, rs1_busy, rs2_busy, m_pending[rs1_in], m_pending[rs2_in]);
      else n_pass++;
      m_we = 0;
      if (exp_ld) begin
        m_we = (ld_rd != 0); m_rd = ld_rd; m_data = ld_data;
        m_pending[ld_rd] = 0; m_wait = 0;
      end else begin
        if (ld_valid) m_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
        if (exp_ex) begin
          m_we = (ex_rd != 0); m_rd = ex_rd; m_data = ex_data;
        end
      end
      if (issue_valid && issue_rd != 0) m_pending[issue_rd] = 1;
      ex_hold = ex_valid && !exp_ex;
      ld_hold = ld_valid && !exp_ld;
      tick();
      n_total++;
      if (write_en !== m_we || (m_we && (rd !== m_rd || write_data !== m_data)))
        $display("FAIL rand_write cyc=%0d got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                 cyc, write_en, rd, write_data, m_we, m_rd, m_data);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_scoreboard();
    test_dual();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
